// File: rtl/test_port_pkg.sv
// Shared definitions for the test-port writer and its sequence checker:
// default port address, framing markers and the writer FSM state encoding.
package test_port_pkg;

    localparam logic [29:0] TEST_PORT = 30'hFF;
    localparam logic [31:0] BEGIN_SYM = 32'h0000_0168;
    localparam logic [31:0] END_SYM   = 32'h0000_0D5D;

    // Direction of the Fibonacci generator step.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } wr_state_t;

endpackage

// File: rtl/test_port_writer_if.sv
// Write bus between the test-port writer (master) and its sink (slave).
//
// Handshake: the master raises wen with addr/data and keeps all three stable
// until a rising edge where wen=1 and stall=0; that edge completes the write.
// stall is the sink's "not ready" and may be asserted at any time.
interface test_port_writer_if;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;
    logic        stall;

    modport master (output addr, output data, output wen, input stall);
    modport slave  (input addr, input data, input wen, output stall);
endinterface

// File: rtl/test_port_writer_fib_gen.sv
// Fibonacci term generator: two 32-bit registers (a = current term,
// b = next term) stepped forward by addition or backward by subtraction.
// Arithmetic wraps modulo 2^32. clear loads the seed fib(0)=0, fib(1)=1.
module fib_gen
    import test_port_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        step,
    input  logic        dir,
    output logic [31:0] term
);

    logic [31:0] a_q;
    logic [31:0] b_q;

    // Seed on clear, otherwise move one term up or down on step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q <= 32'd0;
            b_q <= 32'd0;
        end else if (clear) begin
            a_q <= 32'd0;
            b_q <= 32'd1;
        end else if (step) begin
            if (dir == DIR_UP) begin
                a_q <= b_q;
                b_q <= a_q + b_q;
            end else begin
                a_q <= b_q - a_q;
                b_q <= a_q;
            end
        end
    end

    assign term = a_q;

endmodule

// File: rtl/test_port_writer.sv
// Test-port writer: on a start pulse, writes BEGIN_SYM, FIB_LEN ascending
// Fibonacci terms, the same terms descending, then END_SYM to TEST_PORT.
// Every write is followed by GAP_CYCLES cycles with wen low; stall holds
// the current write. Optional macro TEST_PORT_ERR_INJECT_EN adds inj_en /
// inj_idx, which flip bit 0 of the data of write inj_idx.
module test_port_writer #(
    parameter logic [29:0] TEST_PORT  = test_port_pkg::TEST_PORT,
    parameter logic [31:0] BEGIN_SYM  = test_port_pkg::BEGIN_SYM,
    parameter logic [31:0] END_SYM    = test_port_pkg::END_SYM,
    parameter int          FIB_LEN    = 16,
    parameter int          GAP_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
`ifdef TEST_PORT_ERR_INJECT_EN
    input  logic                    inj_en,
    input  logic [6:0]              inj_idx,
`endif
    test_port_writer_if.master      bus,
    output logic                    busy,
    output logic                    done,
    output logic [6:0]              wr_idx,
    output test_port_pkg::wr_state_t dbg_state
);

    import test_port_pkg::*;

    localparam logic [6:0] FIB_LEN_K = 7'(FIB_LEN);
    localparam logic [6:0] LAST_K    = 7'(2 * FIB_LEN + 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYCLES - 1);

    wr_state_t   state_q;
    logic [6:0]  k_q;
    logic [3:0]  gap_cnt_q;

    logic        launch;
    logic        complete;
    logic        fib_step;
    logic        fib_dir;
    logic [6:0]  k_next;
    logic [31:0] fib_term;
    logic [31:0] next_word;
    logic [31:0] inj_first;
    logic [31:0] inj_next;

`ifdef TEST_PORT_ERR_INJECT_EN
    assign inj_first = {31'd0, inj_en && (inj_idx == 7'd0)};
    assign inj_next  = {31'd0, inj_en && (inj_idx == k_next)};
`else
    assign inj_first = 32'd0;
    assign inj_next  = 32'd0;
`endif

    // Sequencing decisions: start acceptance, write completion, generator
    // stepping, and the data word for the next write index.
    always_comb begin
        launch   = start && ((state_q == IDLE) || (state_q == DONE));
        complete = (state_q == WRITE) && !bus.stall;
        k_next   = k_q + 7'd1;
        // The generator advances after terms 1..FIB_LEN-1 and retreats after
        // FIB_LEN+1..2*FIB_LEN-1; the peak term is written twice, so no step
        // follows write FIB_LEN.
        fib_step = complete && (k_q != 7'd0) && (k_q != FIB_LEN_K)
                   && (k_q < (LAST_K - 7'd1));
        fib_dir  = (k_q > FIB_LEN_K) ? DIR_DOWN : DIR_UP;
        next_word = ((k_next == LAST_K) ? END_SYM : fib_term) ^ inj_next;
    end

    fib_gen u_fib_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (launch),
        .step  (fib_step),
        .dir   (fib_dir),
        .term  (fib_term)
    );

    // Writer FSM with registered bus and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            k_q       <= 7'd0;
            gap_cnt_q <= 4'd0;
            bus.addr  <= 30'd0;
            bus.data  <= 32'd0;
            bus.wen   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            wr_idx    <= 7'd0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (launch) begin
                        state_q  <= WRITE;
                        k_q      <= 7'd0;
                        wr_idx   <= 7'd0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        bus.wen  <= 1'b1;
                        bus.addr <= TEST_PORT;
                        bus.data <= BEGIN_SYM ^ inj_first;
                    end
                end
                WRITE: begin
                    if (complete) begin
                        wr_idx  <= wr_idx + 7'd1;
                        bus.wen <= 1'b0;
                        if (k_q == LAST_K) begin
                            state_q  <= DONE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            bus.addr <= 30'd0;
                            bus.data <= 32'd0;
                        end else begin
                            state_q   <= GAP;
                            gap_cnt_q <= GAP_LAST;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == 4'd0) begin
                        state_q  <= WRITE;
                        k_q      <= k_next;
                        bus.wen  <= 1'b1;
                        bus.data <= next_word;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_test_port_writer.sv
// Bench for test_port_writer: default instance (FIB_LEN=16, GAP_CYCLES=1)
// driven through directed scenarios, plus a FIB_LEN=40 / GAP_CYCLES=3
// instance for the long-sequence and wide-gap boundary.
module tb_test_port_writer;
    import test_port_pkg::*;

    logic clk;
    logic rst;
    logic start;
    logic start40;
    logic busy, done, busy40, done40;
    logic [6:0] wr_idx, wr_idx40;
    wr_state_t dbg_state, dbg_state40;
`ifdef TEST_PORT_ERR_INJECT_EN
    logic inj_en;
    logic [6:0] inj_idx;
`endif

    test_port_writer_if bus ();
    test_port_writer_if bus40 ();

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] cap40[82];
    int cnt40 = 0;
    logic prev_complete = 1'b0;

    test_port_writer u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef TEST_PORT_ERR_INJECT_EN
        .inj_en    (inj_en),
        .inj_idx   (inj_idx),
`endif
        .bus       (bus.master),
        .busy      (busy),
        .done      (done),
        .wr_idx    (wr_idx),
        .dbg_state (dbg_state)
    );

    test_port_writer #(.FIB_LEN(40), .GAP_CYCLES(3)) u_dut40 (
        .clk       (clk),
        .rst       (rst),
        .start     (start40),
`ifdef TEST_PORT_ERR_INJECT_EN
        .inj_en    (1'b0),
        .inj_idx   (7'd0),
`endif
        .bus       (bus40.master),
        .busy      (busy40),
        .done      (done40),
        .wr_idx    (wr_idx40),
        .dbg_state (dbg_state40)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_word(input int fl, input int k);
        logic [31:0] f0, f1, t;
        int i;
        if (k == 0) return 32'h0000_0168;
        if (k == 2 * fl + 1) return 32'h0000_0D5D;
        i = (k <= fl) ? k - 1 : 2 * fl - k;
        f0 = 32'd0;
        f1 = 32'd1;
        for (int j = 0; j < i; j++) begin
            t  = f0 + f1;
            f0 = f1;
            f1 = t;
        end
        return f0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (prev_complete) begin
                n_vec++;
                if (bus.wen) begin
                    n_err++;
                    $display("FAIL wen_gap: wen high right after a completed write");
                end
            end
            prev_complete = bus.wen && !bus.stall;
            if (bus.wen && !bus.stall) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: got data %0h, expected no write", bus.data);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (bus.data !== e) begin
                        n_err++;
                        $display("FAIL write_data: got %0h, expected %0h", bus.data, e);
                    end
                end
                n_vec++;
                if (bus.addr !== 30'hFF) begin
                    n_err++;
                    $display("FAIL write_addr: got %0h, expected ff", bus.addr);
                end
            end
        end else begin
            prev_complete = 1'b0;
        end
    end

    // Capture for the FIB_LEN=40 instance (its sink never stalls).
    always @(negedge clk) begin
        if (rst && bus40.wen) begin
            if (cnt40 < 82) cap40[cnt40] = bus40.data;
            cnt40++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_seq(input int inj_k);
        logic [31:0] w;
        for (int k = 0; k < 34; k++) begin
            w = exp_word(16, k);
            if (k == inj_k) w = w ^ 32'h1;
            exp_q.push_back(w);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 400) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_write(input logic [6:0] n);
        int c;
        c = 0;
        while (!(wr_idx == n && bus.wen) && c < 400) begin
            @(posedge clk); #1;
            c++;
        end
        check("wait_write", {31'd0, (wr_idx == n && bus.wen)}, 32'd1);
    endtask

    task automatic check_idle(input string name);
        check({name, "_wen"},    {31'd0, bus.wen}, 32'd0);
        check({name, "_addr"},   {2'd0, bus.addr}, 32'd0);
        check({name, "_data"},   bus.data, 32'd0);
        check({name, "_busy"},   {31'd0, busy}, 32'd0);
        check({name, "_done"},   {31'd0, done}, 32'd0);
        check({name, "_wr_idx"}, {25'd0, wr_idx}, 32'd0);
        check({name, "_state"},  {30'd0, dbg_state}, {30'd0, IDLE});
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int cyc;
        rst = 1'b0;
        start = 1'b0;
        start40 = 1'b0;
        bus.stall = 1'b0;
        bus40.stall = 1'b0;
`ifdef TEST_PORT_ERR_INJECT_EN
        inj_en = 1'b0;
        inj_idx = 7'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("post_reset_idle");

        // Plain run: first write one cycle after start, 67 cycles to done.
        start_seq(-1);
        check("first_wen", {31'd0, bus.wen}, 32'd1);
        check("first_data", bus.data, 32'h168);
        check("first_busy", {31'd0, busy}, 32'd1);
        wait_done(cyc);
        check("run_cycles", cyc, 32'd67);
        check("run_wr_idx", {25'd0, wr_idx}, 32'd34);
        check("run_busy", {31'd0, busy}, 32'd0);
        check("run_wen", {31'd0, bus.wen}, 32'd0);
        check("run_q_empty", exp_q.size(), 32'd0);

        // Stall for 5 cycles on write 16 (data 610).
        start_seq(-1);
        wait_write(7'd16);
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_wen", {31'd0, bus.wen}, 32'd1);
            check("stall_data", bus.data, 32'd610);
            check("stall_idx", {25'd0, wr_idx}, 32'd16);
        end
        bus.stall = 1'b0;
        @(posedge clk); #1;
        check("stall_gap_wen", {31'd0, bus.wen}, 32'd0);
        check("stall_gap_idx", {25'd0, wr_idx}, 32'd17);
        @(posedge clk); #1;
        check("stall_next_data", bus.data, 32'd610);
        wait_done(cyc);
        check("stall_q_empty", exp_q.size(), 32'd0);

        // Start mid-run is ignored; start in DONE restarts cleanly.
        start_seq(-1);
        wait_write(7'd10);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc);
        check("ignore_q_empty", exp_q.size(), 32'd0);
        start_seq(-1);
        check("restart_done", {31'd0, done}, 32'd0);
        check("restart_wr_idx", {25'd0, wr_idx}, 32'd0);
        check("restart_data", bus.data, 32'h168);
        wait_done(cyc);
        check("restart_cycles", cyc, 32'd67);

        // Asynchronous reset in the middle of a stall at write 20.
        start_seq(-1);
        wait_write(7'd20);
        bus.stall = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_idle("async_reset");
        exp_q.delete();
        bus.stall = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("after_release");
        start_seq(-1);
        wait_done(cyc);
        check("rerun_cycles", cyc, 32'd67);
        check("rerun_q_empty", exp_q.size(), 32'd0);

`ifdef TEST_PORT_ERR_INJECT_EN
        // Corrupt write 5 only; the following terms must stay correct.
        inj_en = 1'b1;
        inj_idx = 7'd5;
        start_seq(5);
        inj_en = 1'b0;
        inj_idx = 7'd0;
        wait_done(cyc);
        check("inject_q_empty", exp_q.size(), 32'd0);
`endif

        // FIB_LEN=40, GAP_CYCLES=3 instance.
        cnt40 = 0;
        start40 = 1'b1;
        @(posedge clk); #1;
        start40 = 1'b0;
        cyc = 0;
        while (!done40 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("f40_done", {31'd0, done40}, 32'd1);
        check("f40_cycles", cyc, 32'd325);
        check("f40_count", cnt40, 32'd82);
        check("f40_begin", cap40[0], 32'h168);
        check("f40_peak_up", cap40[40], 32'd63245986);
        check("f40_peak_down", cap40[41], 32'd63245986);
        check("f40_last_term", cap40[80], 32'd0);
        check("f40_end", cap40[81], 32'hD5D);
        for (int k = 0; k < 82; k++) begin
            check($sformatf("f40_word%0d", k), cap40[k], exp_word(40, k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
